// File: rtl/lcd_frame_writer.sv
`default_nettype none
// ------------------------------------------------------------------------------------------------
// lcd_frame_writer : 32-char frame buffer streamed as 34 items to a 16x2 character-LCD driver.
// Build option LCD_AUTO_REFRESH_EN: restart a frame whenever idle.         Rev 1.0
// ------------------------------------------------------------------------------------------------
module lcd_frame_writer #(
  parameter logic [7:0] LINE1_ADDR  = 8'h80,
  parameter logic [7:0] LINE2_ADDR  = 8'hC0,
  parameter int         ACK_TIMEOUT = 16
) (
  input  logic       clock,
  input  logic       internal_reset,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       update,
  input  logic       lcd_busy,
  output logic [8:0] d_out,
  output logic       data_ready,
  output logic       frame_busy,
  output logic       frame_done
);

  localparam int         TMO_W    = $clog2(ACK_TIMEOUT);
  // STROBE costs one extra cycle, so leave WAIT_ACK one count early: re-strobes land ACK_TIMEOUT apart.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 2);
  localparam logic [5:0] LAST_IDX = 6'd33;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    STROBE    = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [7:0]       char_buf [32];
  logic [5:0]       idx;
  logic [TMO_W-1:0] tmo;
  logic             pending;
  logic             start_req;
  logic             start;
  logic             load;
  logic             fire;
  logic             tmo_inc;
  logic             advance;
  logic             finish;
  logic [4:0]       char_sel;
  logic [8:0]       item;

`ifdef LCD_AUTO_REFRESH_EN
  assign start_req = 1'b1;
`else
  assign start_req = update | pending;
`endif

  // Line 1 chars sit at idx 1-16, line 2 chars at idx 18-33; the 5-bit wrap maps 32/33 to 30/31.
  always_comb begin
    char_sel = (idx <= 6'd16) ? (idx[4:0] - 5'd1) : (idx[4:0] - 5'd2);
    item     = {1'b1, char_buf[char_sel]};
    if (idx == 6'd0) begin
      item = {1'b0, LINE1_ADDR};
    end else if (idx == 6'd17) begin
      item = {1'b0, LINE2_ADDR};
    end
  end

  always_ff @(posedge clock) begin
    if (internal_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    load       = 1'b0;
    fire       = 1'b0;
    tmo_inc    = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start_req) begin
          start      = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        load       = 1'b1;
        state_next = STROBE;
      end
      STROBE: begin
        if (!lcd_busy) begin
          fire       = 1'b1;
          state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (lcd_busy) begin
          state_next = WAIT_DONE;
        end else if (tmo == TMO_LAST) begin
          state_next = STROBE;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!lcd_busy) begin
          if (idx == LAST_IDX) begin
            finish     = 1'b1;
            state_next = IDLE;
          end else begin
            advance    = 1'b1;
            state_next = LOAD;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (internal_reset) begin
      idx        <= 6'd0;
      tmo        <= '0;
      pending    <= 1'b0;
      d_out      <= 9'd0;
      data_ready <= 1'b0;
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        char_buf[i] <= 8'h20;
      end
    end else begin
      data_ready <= fire;
      frame_done <= finish;
      if (wr_en) begin
        char_buf[wr_addr] <= wr_data;
      end
      // An update arriving while a frame is running is remembered; starting a frame consumes it.
      if (start) begin
        pending    <= 1'b0;
        idx        <= 6'd0;
        frame_busy <= 1'b1;
      end else if (update) begin
        pending <= 1'b1;
      end
      if (finish) begin
        frame_busy <= 1'b0;
      end
      if (advance) begin
        idx <= idx + 1'b1;
      end
      if (load) begin
        d_out <= item;
      end
      if (fire) begin
        tmo <= '0;
      end else if (tmo_inc) begin
        tmo <= tmo + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_frame_writer.sv
`default_nettype none
// Bench for lcd_frame_writer: behavioural LCD-driver model plus a reference frame built from a buffer mirror.
module tb_lcd_frame_writer;

  localparam int ACK_TIMEOUT = 16;

  logic       clock = 1'b0;
  logic       internal_reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = 5'd0;
  logic [7:0] wr_data = 8'd0;
  logic       update = 1'b0;
  logic       lcd_busy;
  logic [8:0] d_out;
  logic       data_ready;
  logic       frame_busy;
  logic       frame_done;

  lcd_frame_writer #(
    .LINE1_ADDR (8'h80),
    .LINE2_ADDR (8'hC0),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clock         (clock),
    .internal_reset(internal_reset),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .update        (update),
    .lcd_busy      (lcd_busy),
    .d_out         (d_out),
    .data_ready    (data_ready),
    .frame_busy    (frame_busy),
    .frame_done    (frame_done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // LCD driver model: after an accepted strobe, raise busy after ack_delay cycles for busy_len cycles.
  int         ack_delay = 1;
  int         busy_len = 40;
  int         ignore_cnt = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         dr_busy_cnt = 0;
  int         dcnt = 0;
  int         bcnt = 0;
  bit         ack_pend = 1'b0;
  logic       model_busy = 1'b0;
  logic       force_busy = 1'b0;
  logic [8:0] items[$];
  int         strobe_t[$];
  logic [7:0] ref_buf[32];

  assign lcd_busy = model_busy | force_busy;

  always @(negedge clock) begin
    cyc++;
    if (internal_reset) begin
      model_busy = 1'b0;
      ack_pend   = 1'b0;
    end else begin
      if (frame_done) done_cnt++;
      if (data_ready && lcd_busy) dr_busy_cnt++;
      if (ack_pend) begin
        if (dcnt == 0) begin
          model_busy = 1'b1;
          ack_pend   = 1'b0;
          bcnt       = busy_len;
        end else begin
          dcnt--;
        end
      end else if (model_busy) begin
        if (bcnt == 0) model_busy = 1'b0;
        else bcnt--;
      end
      if (data_ready) begin
        strobe_t.push_back(cyc);
        if (ignore_cnt > 0) begin
          ignore_cnt--;
        end else begin
          items.push_back(d_out);
          ack_pend = 1'b1;
          dcnt     = ack_delay;
        end
      end
    end
  end

  function automatic logic [8:0] exp_item(input int i);
    if (i == 0)  return {1'b0, 8'h80};
    if (i <= 16) return {1'b1, ref_buf[i-1]};
    if (i == 17) return {1'b0, 8'hC0};
    return {1'b1, ref_buf[i-2]};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    internal_reset = 1'b1;
    update = 1'b0;
    wr_en = 1'b0;
    force_busy = 1'b0;
    ignore_cnt = 0;
    tick(2);
    internal_reset = 1'b0;
    for (int i = 0; i < 32; i++) ref_buf[i] = 8'h20;
    tick(1);
    items.delete();
    strobe_t.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_update();
    update = 1'b1;
    tick();
    update = 1'b0;
  endtask

  task automatic write_char(input int a, input logic [7:0] c);
    wr_en = 1'b1;
    wr_addr = 5'(a);
    wr_data = c;
    tick();
    wr_en = 1'b0;
    ref_buf[a] = c;
  endtask

  task automatic wait_frames(input int n, output bit ok);
    int t = 0;
    while (done_cnt < n && t < 20000) begin
      tick();
      t++;
    end
    ok = (done_cnt >= n);
    tick(2);
  endtask

  task automatic test_reset();
    internal_reset = 1'b1;
    tick(2);
    checks++;
    if ({d_out, data_ready, frame_busy, frame_done} !== 12'd0) begin
      errors++;
      $display("FAIL reset_outputs: got d_out=%h dr=%b fb=%b fd=%b, want all zero",
               d_out, data_ready, frame_busy, frame_done);
    end
    do_reset();
    tick(20);
    checks++;
    if (strobe_t.size() != 0 || frame_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_without_update: got %0d strobes fb=%b, want 0 strobes fb=0", strobe_t.size(), frame_busy);
    end
  endtask

  task automatic test_default_frame();
    int lat;
    bit ok;
    int bad = 0;
    do_reset();
    ack_delay = 1;
    busy_len = 40;
    pulse_update();
    lat = 1;
    while (!data_ready && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL first_strobe_latency: got %0d cycles, want 3", lat);
    end
    wait_frames(1, ok);
    checks++;
    if (!ok || items.size() != 34) begin
      errors++;
      $display("FAIL default_frame_len: got %0d items ok=%0b, want 34", items.size(), ok);
    end
    for (int i = 0; i < 34 && i < items.size(); i++) begin
      checks++;
      if (items[i] !== exp_item(i)) begin
        errors++;
        bad++;
        $display("FAIL default_item[%0d]: got %h, want %h", i, items[i], exp_item(i));
      end
    end
    checks++;
    if (done_cnt != 1 || dr_busy_cnt != 0) begin
      errors++;
      $display("FAIL default_done: got frame_done cycles=%0d strobes_while_busy=%0d, want 1 and 0",
               done_cnt, dr_busy_cnt);
    end
  endtask

  task automatic test_calc_string();
    string s = "12+3=15";
    logic [8:0] want[7] = '{9'h131, 9'h132, 9'h12B, 9'h133, 9'h13D, 9'h131, 9'h135};
    bit ok;
    do_reset();
    ack_delay = 0;
    busy_len = 12;
    for (int i = 0; i < 7; i++) write_char(i, s[i]);
    write_char(31, 8'h45);
    pulse_update();
    wait_frames(1, ok);
    checks++;
    if (!ok || items.size() != 34) begin
      errors++;
      $display("FAIL calc_frame_len: got %0d items, want 34", items.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (items[i+1] !== want[i]) begin
          errors++;
          $display("FAIL calc_item[%0d]: got %h, want %h", i + 1, items[i+1], want[i]);
        end
      end
      checks++;
      if (items[33] !== 9'h145) begin
        errors++;
        $display("FAIL calc_item[33]: got %h, want 145", items[33]);
      end
      checks++;
      if (items[17] !== 9'h0C0 || items[18] !== 9'h120) begin
        errors++;
        $display("FAIL calc_line2_start: got %h %h, want 0c0 120", items[17], items[18]);
      end
    end
  endtask

  task automatic test_random_frames();
    bit ok;
    int t;
    for (int f = 0; f < 3; f++) begin
      for (int w = 0; w < 10; w++) write_char($urandom_range(0, 31), 8'($urandom_range(32, 126)));
      ack_delay = $urandom_range(0, 4);
      busy_len = $urandom_range(3, 50);
      items.delete();
      done_cnt = 0;
      pulse_update();
      t = 0;
      while (items.size() < 2 && t < 2000) begin
        tick();
        t++;
      end
      // the last char of line 2 is still unsent, so this write must show up in this frame
      write_char(31, 8'($urandom_range(32, 126)));
      wait_frames(1, ok);
      checks++;
      if (!ok || items.size() != 34) begin
        errors++;
        $display("FAIL rand_frame%0d_len: got %0d items, want 34", f, items.size());
      end
      for (int i = 0; i < 34 && i < items.size(); i++) begin
        if (items[i] !== exp_item(i)) begin
          errors++;
          $display("FAIL rand_frame%0d_item[%0d]: got %h, want %h", f, i, items[i], exp_item(i));
        end
      end
      checks++;
    end
  endtask

  task automatic test_busy_hold();
    bit ok;
    do_reset();
    ack_delay = 1;
    busy_len = 20;
    force_busy = 1'b1;
    tick(100);
    pulse_update();
    tick(4900);
    checks++;
    if (strobe_t.size() != 0) begin
      errors++;
      $display("FAIL busy_hold_strobes: got %0d strobes, want 0", strobe_t.size());
    end
    force_busy = 1'b0;
    wait_frames(1, ok);
    checks++;
    if (!ok || items.size() != 34 || items[0] !== 9'h080) begin
      errors++;
      $display("FAIL busy_hold_frame: got %0d items first=%h, want 34 first=080",
               items.size(), (items.size() > 0) ? items[0] : 9'h1FF);
    end
  endtask

  task automatic test_ack_timeout();
    bit ok;
    int gap;
    do_reset();
    ack_delay = 2;
    busy_len = 10;
    ignore_cnt = 1;
    pulse_update();
    wait_frames(1, ok);
    gap = (strobe_t.size() >= 2) ? strobe_t[1] - strobe_t[0] : -1;
    checks++;
    if (gap != ACK_TIMEOUT) begin
      errors++;
      $display("FAIL restrobe_gap: got %0d cycles, want %0d", gap, ACK_TIMEOUT);
    end
    checks++;
    if (!ok || strobe_t.size() != 35 || items.size() != 34 || items[0] !== 9'h080) begin
      errors++;
      $display("FAIL timeout_frame: got strobes=%0d items=%0d, want 35 and 34 starting 080",
               strobe_t.size(), items.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int t = 0;
    do_reset();
    ack_delay = 1;
    busy_len = 8;
    write_char(5, 8'h41);
    pulse_update();
    while (items.size() < 5 && t < 2000) begin
      tick();
      t++;
    end
    for (int p = 0; p < 3; p++) begin
      pulse_update();
      tick(7);
    end
    wait_frames(2, ok);
    tick(600);
    checks++;
    if (!ok || done_cnt != 2 || items.size() != 68) begin
      errors++;
      $display("FAIL coalesce: got frame_done=%0d items=%0d, want 2 and 68", done_cnt, items.size());
    end
    for (int i = 0; i < items.size(); i++) begin
      if (items[i] !== exp_item(i % 34)) begin
        errors++;
        $display("FAIL b2b_item[%0d]: got %h, want %h", i, items[i], exp_item(i % 34));
      end
    end
    checks++;
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int t = 0;
    int n;
    do_reset();
    ack_delay = 1;
    busy_len = 15;
    for (int i = 0; i < 32; i += 3) write_char(i, 8'h58);
    pulse_update();
    while (items.size() < 21 && t < 4000) begin
      tick();
      t++;
    end
    internal_reset = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (data_ready !== 1'b0 || frame_busy !== 1'b0 || d_out !== 9'd0) begin
      errors++;
      $display("FAIL reset_abort: got dr=%b fb=%b d_out=%h, want 0 0 000", data_ready, frame_busy, d_out);
    end
    tick(2);
    internal_reset = 1'b0;
    for (int i = 0; i < 32; i++) ref_buf[i] = 8'h20;
    n = strobe_t.size();
    tick(300);
    checks++;
    if (strobe_t.size() != n || frame_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got %0d new strobes fb=%b, want 0 fb=0", strobe_t.size() - n, frame_busy);
    end
    items.delete();
    done_cnt = 0;
    pulse_update();
    wait_frames(1, ok);
    checks++;
    if (!ok || items.size() != 34) begin
      errors++;
      $display("FAIL post_reset_len: got %0d items, want 34", items.size());
    end
    for (int i = 0; i < 34 && i < items.size(); i++) begin
      if (items[i] !== exp_item(i)) begin
        errors++;
        $display("FAIL post_reset_item[%0d]: got %h, want %h", i, items[i], exp_item(i));
      end
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_default_frame();
    test_calc_string();
    test_random_frames();
    test_busy_hold();
    test_ack_timeout();
    test_back_to_back();
    test_reset_mid_frame();
    checks++;
    if (dr_busy_cnt != 0) begin
      errors++;
      $display("FAIL strobe_while_busy: got %0d, want 0", dr_busy_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
